// File: rtl/adder_pkg.sv
// Shared sizing defaults for the pipelined adder and its slice helper.
package adder_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_STAGES = 4;
  localparam int DEF_SW     = DEF_WIDTH / DEF_STAGES;

  // Bits handled by each pipeline stage.
  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple-carry slice built from full-adder cells.
// cmsb exposes the carry into the slice MSB so the top can form signed overflow.
module adder_slice #(
  parameter int SW = 16
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          cmsb
);

  logic [SW:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SW; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SW];
  assign cmsb = c[SW-1];

endmodule

// File: rtl/pipe_adder.sv
// Carry-pipelined adder/subtractor: stage k adds operand slice k using the
// carry registered by stage k-1. Operands and finished result slices ride
// along with the data. A full-pipeline stall occurs only when the output is
// held by downstream; otherwise one result per cycle after STAGES cycles.
// WIDTH must be a multiple of STAGES.
// Optional feature macro: PIPE_ADDER_OVF_EN enables the signed overflow flag;
// without it ovf is tied low and no overflow logic exists.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             C,
  output logic             ovf
);

  localparam int SW = slice_w(WIDTH, STAGES);

  // Whole pipeline moves unless the last stage holds a result nobody takes.
  logic adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] a_i, b_i, s_i;
    logic             c_i, v_i;
    logic [SW-1:0]    sl_sum;
    logic             sl_cout, sl_cmsb;
    logic [WIDTH-1:0] s_nx;
    logic [WIDTH-1:0] a_p, b_p, s_p;
    logic             c_p, vld_p;
    logic             unused_bits;

    // ---- stage k input: ports for stage 0, previous stage otherwise ----
    if (k == 0) begin : g_first
      assign a_i = x;
      assign b_i = sub ? ~y : y;
      assign s_i = '0;
      assign c_i = cin;
      assign v_i = in_valid;
    end else begin : g_next
      assign a_i = g_st[k-1].a_p;
      assign b_i = g_st[k-1].b_p;
      assign s_i = g_st[k-1].s_p;
      assign c_i = g_st[k-1].c_p;
      assign v_i = g_st[k-1].vld_p;
    end

    adder_slice #(.SW(SW)) u_slice (
      .a    (a_i[k*SW +: SW]),
      .b    (b_i[k*SW +: SW]),
      .cin  (c_i),
      .sum  (sl_sum),
      .cout (sl_cout),
      .cmsb (sl_cmsb)
    );

    // Insert this stage's slice into the travelling partial result.
    always_comb begin
      s_nx = s_i;
      s_nx[k*SW +: SW] = sl_sum;
    end

    // Stage valid bit; only control state is cleared by reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p <= 1'b0;
      end else if (adv) begin
        vld_p <= v_i;
      end
    end

    // Operands travel unmodified for the stages further up.
    always_ff @(posedge clk) begin
      if (adv) begin
        a_p <= a_i;
        b_p <= b_i;
      end
    end

    // ---- stage k output register: partial sum and slice carry ----
    if (k == STAGES - 1) begin : g_last
      // Visible result register clears on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          s_p <= '0;
          c_p <= 1'b0;
        end else if (adv) begin
          s_p <= s_nx;
          c_p <= sl_cout;
        end
      end
    end else begin : g_mid
      // Intermediate data carries no reset; its valid bit gates it.
      always_ff @(posedge clk) begin
        if (adv) begin
          s_p <= s_nx;
          c_p <= sl_cout;
        end
      end
    end

    // Last-stage operand copies and non-final MSB taps have no consumer.
    assign unused_bits = ^{a_p, b_p, sl_cmsb};
  end

  assign out_valid = g_st[STAGES-1].vld_p;
  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;
  assign z         = g_st[STAGES-1].s_p;
  assign C         = g_st[STAGES-1].c_p;

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_p;

  // Overflow = carry into MSB xor carry out of MSB, registered alongside z.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_p <= 1'b0;
    end else if (adv) begin
      ovf_p <= g_st[STAGES-1].sl_cmsb ^ g_st[STAGES-1].sl_cout;
    end
  end

  assign ovf = ovf_p;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: default 64/4 build plus 8/1 and 32/8
// instances, all compared against an arithmetic reference model.
module tb_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 64-bit, 4-stage instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, C, ovf;
  logic [63:0] x, y, z;
  // 8-bit, 1-stage instance
  logic        in_valid_n, in_ready_n, cin_n, sub_n, out_valid_n, out_ready_n, C_n, ovf_n;
  logic [7:0]  x_n, y_n, z_n;
  // 32-bit, 8-stage instance
  logic        in_valid_w, in_ready_w, cin_w, sub_w, out_valid_w, out_ready_w, C_w, ovf_w;
  logic [31:0] x_w, y_w, z_w;

  pipe_adder #(.WIDTH(64), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .C(C), .ovf(ovf)
  );

  pipe_adder #(.WIDTH(8), .STAGES(1)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n),
    .x(x_n), .y(y_n), .cin(cin_n), .sub(sub_n),
    .out_valid(out_valid_n), .out_ready(out_ready_n), .z(z_n), .C(C_n), .ovf(ovf_n)
  );

  pipe_adder #(.WIDTH(32), .STAGES(8)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .x(x_w), .y(y_w), .cin(cin_w), .sub(sub_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .z(z_w), .C(C_w), .ovf(ovf_w)
  );

  typedef struct packed {
    logic [63:0] z;
    logic        c;
    logic        v;
  } res_t;

  res_t q64[$];
  res_t q8[$];
  res_t q32[$];

  int n_cmp = 0;
  int n_err = 0;

`ifdef PIPE_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  // Reference: w-bit two's-complement add of x and (sub ? ~y : y) plus cin.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic sb);
    res_t        r;
    logic [63:0] m, aa, bb;
    logic [64:0] full;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = a & m;
    bb   = (sb ? ~b : b) & m;
    full = {1'b0, aa} + {1'b0, bb} + {64'd0, ci};
    r.z  = full[63:0] & m;
    r.c  = full[w];
    r.v  = OVF_ON && (aa[w-1] == bb[w-1]) && (r.z[w-1] != aa[w-1]);
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = 64'h8000_0000_0000_0000;
      2:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      3:       v = 64'd0;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; x = 64'd11; y = 64'd22; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (z !== 64'd0) begin n_err++; $display("FAIL reset_z got %h exp 0", z); end
    n_cmp++; if (C !== 1'b0) begin n_err++; $display("FAIL reset_C got %b exp 0", C); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    n_cmp++; if (out_valid_n !== 1'b0 || out_valid_w !== 1'b0) begin
      n_err++; $display("FAIL reset_narrow_wide got %b/%b exp 0/0", out_valid_n, out_valid_w);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    // The operand presented during reset must never emerge.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_ignored_in cycle %0d got %b exp 0", c, out_valid); end
    end
  endtask

  task automatic test_directed();
    logic [63:0] tx[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000};
    logic [63:0] ty[3] = '{64'd1, 64'd7, 64'd1};
    logic        tc[3] = '{1'b0, 1'b1, 1'b1};
    logic        ts[3] = '{1'b0, 1'b1, 1'b1};
    logic [63:0] ez[3] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFF};
    logic        ec[3] = '{1'b1, 1'b0, 1'b1};
    logic        ev[3] = '{1'b0, 1'b0, OVF_ON};
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      x = tx[t]; y = ty[t]; cin = tc[t]; sub = ts[t]; in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (c < 4) begin
          n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_latency cycle %0d got %b exp 0", t, c, out_valid); end
        end
      end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_valid got %b exp 1", t, out_valid); end
      n_cmp++; if (z !== ez[t]) begin n_err++; $display("FAIL dir%0d_z got %h exp %h", t, z, ez[t]); end
      n_cmp++; if (C !== ec[t]) begin n_err++; $display("FAIL dir%0d_C got %b exp %b", t, C, ec[t]); end
      n_cmp++; if (ovf !== ev[t]) begin n_err++; $display("FAIL dir%0d_ovf got %b exp %b", t, ovf, ev[t]); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int   n_in = 0, n_out = 0, first = -1, last = -1;
    res_t e;
    for (int i = 0; i < 200 && n_out < 100; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (n_in < 100);
      x = rand64(); y = rand64(); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q64.size() == 0) begin
          n_err++; $display("FAIL b2b_extra cycle %0d got unexpected result %h", i, z);
        end else begin
          e = q64.pop_front();
          if ({z, C, ovf} !== {e.z, e.c, e.v}) begin
            n_err++; $display("FAIL b2b_result #%0d got z=%h C=%b ovf=%b exp z=%h C=%b ovf=%b",
                              n_out, z, C, ovf, e.z, e.c, e.v);
          end
          if (first < 0) first = i;
          last = i;
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        q64.push_back(model(64, x, y, cin, sub));
        n_in++;
      end
    end
    n_cmp++; if (n_out != 100) begin n_err++; $display("FAIL b2b_count got %0d exp 100", n_out); end
    n_cmp++; if (first != 4) begin n_err++; $display("FAIL b2b_first_cycle got %0d exp 4", first); end
    n_cmp++; if (last - first != 99) begin n_err++; $display("FAIL b2b_span got %0d exp 99", last - first); end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic        prev_stall = 1'b0;
    logic [63:0] pz = '0;
    logic        pc = 1'b0, pv = 1'b0;
    int          n_in = 0, n_out = 0;
    res_t        e;
    for (int i = 0; i < 340; i++) begin
      @(negedge clk);
      in_valid  = (i < 300);
      out_ready = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
      x = rand64(); y = rand64(); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_err++; $display("FAIL stall_in_ready cycle %0d got %b exp %b", i, in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || {z, C, ovf} !== {pz, pc, pv}) begin
          n_err++; $display("FAIL stall_hold cycle %0d got v=%b z=%h C=%b ovf=%b exp v=1 z=%h C=%b ovf=%b",
                            i, out_valid, z, C, ovf, pz, pc, pv);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q64.size() == 0) begin
          n_err++; $display("FAIL stall_extra cycle %0d got unexpected result %h", i, z);
        end else begin
          e = q64.pop_front();
          if ({z, C, ovf} !== {e.z, e.c, e.v}) begin
            n_err++; $display("FAIL stall_result #%0d got z=%h C=%b ovf=%b exp z=%h C=%b ovf=%b",
                              n_out, z, C, ovf, e.z, e.c, e.v);
          end
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        q64.push_back(model(64, x, y, cin, sub));
        n_in++;
      end
      prev_stall = out_valid && !out_ready;
      pz = z; pc = C; pv = ovf;
    end
    n_cmp++;
    if (q64.size() != 0 || n_in != n_out) begin
      n_err++; $display("FAIL stall_lost got %0d out of %0d accepted exp all", n_out, n_in);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x = rand64(); y = rand64(); cin = 1'b1; sub = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; x = 64'd100; y = 64'd200;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (z !== 64'd0 || C !== 1'b0) begin n_err++; $display("FAIL flush_zc got z=%h C=%b exp 0/0", z, C); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b1; x = 64'd2; y = 64'd3; cin = 1'b0; sub = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (c < 4) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stale cycle %0d got %b exp 0", c, out_valid); end
      end
    end
    n_cmp++; if (out_valid !== 1'b1 || z !== 64'd5 || C !== 1'b0) begin
      n_err++; $display("FAIL flush_after got v=%b z=%h C=%b exp v=1 z=5 C=0", out_valid, z, C);
    end
    @(negedge clk);
  endtask

  task automatic test_narrow8();
    int   n_out = 0;
    res_t e;
    out_ready_n = 1'b1;
    for (int i = 0; i < 65536 + 4; i++) begin
      @(negedge clk);
      in_valid_n = (i < 65536);
      x_n = 8'(i); y_n = 8'(i >> 8);
      cin_n = 1'($urandom_range(0, 1)); sub_n = 1'($urandom_range(0, 1));
      #1;
      if (i == 1) begin
        n_cmp++; if (out_valid_n !== 1'b1) begin n_err++; $display("FAIL n8_latency got %b exp 1", out_valid_n); end
      end
      if (out_valid_n && out_ready_n) begin
        n_cmp++;
        if (q8.size() == 0) begin
          n_err++; $display("FAIL n8_extra cycle %0d got %h", i, z_n);
        end else begin
          e = q8.pop_front();
          if ({z_n, C_n, ovf_n} !== {e.z[7:0], e.c, e.v}) begin
            n_err++; $display("FAIL n8_result #%0d got z=%h C=%b ovf=%b exp z=%h C=%b ovf=%b",
                              n_out, z_n, C_n, ovf_n, e.z[7:0], e.c, e.v);
          end
          n_out++;
        end
      end
      if (in_valid_n && in_ready_n) q8.push_back(model(8, {56'd0, x_n}, {56'd0, y_n}, cin_n, sub_n));
    end
    n_cmp++; if (n_out != 65536) begin n_err++; $display("FAIL n8_count got %0d exp 65536", n_out); end
    in_valid_n = 1'b0;
  endtask

  task automatic test_wide32();
    int   n_in = 0, n_out = 0;
    res_t e;
    for (int i = 0; i < 560; i++) begin
      @(negedge clk);
      in_valid_w  = (i < 500);
      out_ready_w = (i < 500) ? 1'($urandom_range(0, 1)) : 1'b1;
      x_w = $urandom; y_w = (i % 9 == 0) ? 32'hFFFF_FFFF : $urandom;
      cin_w = 1'($urandom_range(0, 1)); sub_w = 1'($urandom_range(0, 1));
      #1;
      if (out_valid_w && out_ready_w) begin
        n_cmp++;
        if (q32.size() == 0) begin
          n_err++; $display("FAIL w32_extra cycle %0d got %h", i, z_w);
        end else begin
          e = q32.pop_front();
          if ({z_w, C_w, ovf_w} !== {e.z[31:0], e.c, e.v}) begin
            n_err++; $display("FAIL w32_result #%0d got z=%h C=%b ovf=%b exp z=%h C=%b ovf=%b",
                              n_out, z_w, C_w, ovf_w, e.z[31:0], e.c, e.v);
          end
          n_out++;
        end
      end
      if (in_valid_w && in_ready_w) begin
        q32.push_back(model(32, {32'd0, x_w}, {32'd0, y_w}, cin_w, sub_w));
        n_in++;
      end
    end
    n_cmp++; if (q32.size() != 0 || n_in != n_out) begin
      n_err++; $display("FAIL w32_lost got %0d out of %0d accepted exp all", n_out, n_in);
    end
    in_valid_w = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid_n = 1'b0; x_n = '0; y_n = '0; cin_n = 1'b0; sub_n = 1'b0; out_ready_n = 1'b1;
    in_valid_w = 1'b0; x_w = '0; y_w = '0; cin_w = 1'b0; sub_w = 1'b0; out_ready_w = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_narrow8();
    test_wide32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline stages; WIDTH SHALL be divisible by STAGES; slice width SW = WIDTH/STAGES.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operand set present.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 SHALL have port x, input, WIDTH, operand A.
REQ-008 SHALL have port y, input, WIDTH, operand B.
REQ-009 SHALL have port cin, input, 1, carry-in.
REQ-010 SHALL have port sub, input, 1, 1 = compute x - y + cin - 1 (x + ~y + cin).
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-013 SHALL have port z, output, WIDTH, sum/difference, modulo 2^WIDTH.
REQ-014 SHALL have port C, output, 1, carry-out of MSB.
REQ-015 SHALL have port ovf, output, 1, signed two's-complement overflow.

Function
REQ-016 Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 Stage k (0..STAGES-1) SHALL add slice k (bits k*SW+SW-1 : k*SW) using carry registered from stage k-1 (stage 0 uses cin); unprocessed upper operand slices and completed lower result slices travel with the data.
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall; throughput one result per cycle.
REQ-019 Each stage SHALL hold a valid bit; pipeline advances when !(out_valid && !out_ready); in_ready = !(out_valid && !out_ready) (combinational, no bubble required).
REQ-020 On stall all stage registers, including z/C/ovf, SHALL hold; no transaction is lost or duplicated.
REQ-021 Bubbles (in_valid low) SHALL propagate as invalid stages; valid results stay in order.
REQ-022 z/C/ovf SHALL remain stable while out_valid && !out_ready.
REQ-023 STAGES = 1 SHALL yield a single-register adder with latency 1.
REQ-024 C SHALL equal raw carry-out of x + (sub ? ~y : y) + cin (for subtract, C = 1 means no borrow).

Reset
REQ-025 On rst, all stage valid bits, out_valid, z, C, ovf SHALL clear to 0 at next edge.
REQ-026 Reset mid-operation SHALL discard all in-flight data; in_ready = 1 in the cycle after reset.
REQ-027 Input transfers in a reset cycle SHALL be ignored.

Configuration
REQ-028 Macro PIPE_ADDER_OVF_EN defined: ovf = carry into MSB XOR carry out of MSB, aligned with z.
REQ-029 Macro undefined: ovf tied to 0, no overflow logic or register present; all other behaviour identical.

Structure
REQ-030 Package adder_pkg SHALL hold default width (64), default stage count (4), and the slice-width helper constant.
REQ-031 One sub-module adder_slice (combinational SW-bit ripple of full-adder cells with cin/cout, and MSB carry-in tap) SHALL be instantiated once per stage.

Verification
REQ-032 WIDTH=64, STAGES=4: x=0xFFFF_FFFF_FFFF_FFFF, y=1, cin=0, sub=0 -> after 4 cycles z=0, C=1, ovf=0.
REQ-033 sub=1, x=5, y=7, cin=1 -> z=0xFFFF_FFFF_FFFF_FFFE, C=0; x=0x8000_0000_0000_0000, y=1, sub=1, cin=1 -> ovf=1 (OVF_EN defined).
REQ-034 Back-to-back stream of 100 random operands, out_ready held 1 -> 100 results in order, one per cycle after 4-cycle latency, matching reference model.
REQ-035 Random out_ready toggling (50%) with continuous in_valid -> in_ready drops exactly when out_valid && !out_ready; no loss, no duplication, outputs stable during stall.
REQ-036 Assert rst with 3 operations in flight -> next cycle out_valid=0, z=0, C=0; subsequent operation x=2, y=3 -> z=5 after 4 cycles.
REQ-037 Regress WIDTH=8/STAGES=1 and WIDTH=32/STAGES=8, with and without PIPE_ADDER_OVF_EN -> exhaustive (8-bit) or random results match model; ovf constant 0 when macro undefined.
